// File: rtl/fragment_writer.sv
// Rasterizer fragment sink: clips fragments, converts them to framebuffer word
// addresses and queues {addr, colour} writes toward the framebuffer memory port.
module fragment_writer #(
    parameter int CORD_WIDTH  = 10,
    parameter int FB_WIDTH    = 640,
    parameter int FB_HEIGHT   = 480,
    parameter int ADDR_WIDTH  = 19,
    parameter int COLOR_WIDTH = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [COLOR_WIDTH-1:0] i_color,
    input  logic                   i_frag_valid,
    input  logic [CORD_WIDTH-1:0]  i_frag_x,
    input  logic [CORD_WIDTH-1:0]  i_frag_y,
    input  logic                   i_raster_done,
    output logic                   o_mem_valid,
    input  logic                   i_mem_ready,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    output logic [COLOR_WIDTH-1:0] o_mem_data,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_overflow,
    output logic [15:0]            o_frag_count,
    output logic [15:0]            o_clip_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    logic [1:0]             r_state;
    logic [COLOR_WIDTH-1:0] r_color;
    logic [ADDR_WIDTH-1:0]  r_fifo_addr [FIFO_DEPTH];
    logic [COLOR_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [PW:0]            r_cnt;
    logic                   r_done;
    logic                   r_overflow;
    logic [15:0]            r_frag_count;
    logic [15:0]            r_clip_count;

    logic signed [CORD_WIDTH-1:0] w_fx;
    logic signed [CORD_WIDTH-1:0] w_fy;
    int                           w_xi;
    int                           w_yi;
    logic                         w_clip;
    logic [ADDR_WIDTH-1:0]        w_addr;
    logic                         w_accept_start;
    logic                         w_frag;
    logic                         w_pop;
    logic                         w_push;
    logic                         w_drop;
    logic                         w_drain_done;

    // Coordinates are signed; widen to int so the bounds tests are signed compares.
    assign w_fx   = i_frag_x;
    assign w_fy   = i_frag_y;
    assign w_xi   = int'(w_fx);
    assign w_yi   = int'(w_fy);
    assign w_clip = (w_xi < 0) || (w_xi >= FB_WIDTH) || (w_yi < 0) || (w_yi >= FB_HEIGHT);
    assign w_addr = ADDR_WIDTH'(w_yi * FB_WIDTH + w_xi);

    assign w_accept_start = (r_state == S_IDLE) && i_start;
    assign w_frag         = (r_state == S_ACTIVE) && i_frag_valid;
    assign w_pop          = (r_cnt != '0) && i_mem_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push         = w_frag && !w_clip && ((r_cnt != FULL_CNT) || w_pop);
    assign w_drop         = w_frag && !w_clip && !w_push;
    assign w_drain_done   = (r_state == S_DRAIN) && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_color <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_state <= S_ACTIVE;
                    r_color <= i_color;
                end
                S_ACTIVE: if (i_raster_done) r_state <= S_DRAIN;
                S_DRAIN:  if (w_drain_done) r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_addr[i] <= '0;
                r_fifo_data[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wptr] <= w_addr;
                r_fifo_data[r_wptr] <= r_color;
                r_wptr              <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_frag_count <= '0;
            r_clip_count <= '0;
        end else begin
            r_done <= w_drain_done;
            if (w_accept_start) begin
                r_overflow   <= 1'b0;
                r_frag_count <= '0;
                r_clip_count <= '0;
            end else begin
                if (w_drop) r_overflow <= 1'b1;
                if (w_push && (r_frag_count != 16'hFFFF))
                    r_frag_count <= r_frag_count + 16'd1;
                if (w_frag && w_clip && (r_clip_count != 16'hFFFF))
                    r_clip_count <= r_clip_count + 16'd1;
            end
        end
    end

    assign o_mem_valid  = (r_cnt != '0);
    assign o_mem_addr   = r_fifo_addr[r_rptr];
    assign o_mem_data   = r_fifo_data[r_rptr];
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;
    assign o_overflow   = r_overflow;
    assign o_frag_count = r_frag_count;
    assign o_clip_count = r_clip_count;

endmodule

// File: tb/tb_fragment_writer.sv
// Bench for fragment_writer: fragment table, hand-written corner sequences and
// randomized triangles, all checked against a queue-based reference model.
module tb_fragment_writer;

    localparam int CW = 11, FBW = 640, FBH = 480, AW = 19, COLW = 16, DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                  start = 0, frag_valid = 0, raster_done = 0, mem_ready = 0;
    logic [COLW-1:0]       color = '0;
    logic signed [CW-1:0]  frag_x = '0, frag_y = '0;
    logic                  mem_valid, busy, done, overflow;
    logic [AW-1:0]         mem_addr;
    logic [COLW-1:0]       mem_data;
    logic [15:0]           frag_count, clip_count;

    fragment_writer #(
        .CORD_WIDTH(CW), .FB_WIDTH(FBW), .FB_HEIGHT(FBH),
        .ADDR_WIDTH(AW), .COLOR_WIDTH(COLW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_color(color),
        .i_frag_valid(frag_valid), .i_frag_x(frag_x), .i_frag_y(frag_y),
        .i_raster_done(raster_done), .o_mem_valid(mem_valid), .i_mem_ready(mem_ready),
        .o_mem_addr(mem_addr), .o_mem_data(mem_data), .o_busy(busy), .o_done(done),
        .o_overflow(overflow), .o_frag_count(frag_count), .o_clip_count(clip_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending writes as a queue plus the triangle-level status.
    typedef struct { logic [AW-1:0] addr; logic [COLW-1:0] data; } wr_t;
    wr_t          m_q[$];
    int           m_state;   // 0 idle, 1 accepting fragments, 2 draining
    logic [15:0]  m_color;
    int           m_frag, m_clip;
    bit           m_ovf, m_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_state = 0; m_color = '0; m_frag = 0; m_clip = 0; m_ovf = 0; m_done = 0;
    endtask

    // One clock: advance the model with the current inputs, clock, then compare.
    task automatic step();
        bit pop, push, nd;
        int xs, ys;
        wr_t e;
        xs = int'(frag_x);
        ys = int'(frag_y);
        pop = (m_q.size() > 0) && mem_ready;
        push = 0;
        nd = 0;
        case (m_state)
            0: if (start) begin
                m_state = 1; m_color = color; m_frag = 0; m_clip = 0; m_ovf = 0;
            end
            1: begin
                if (frag_valid) begin
                    if (xs < 0 || xs >= FBW || ys < 0 || ys >= FBH) begin
                        if (m_clip < 65535) m_clip++;
                    end else if (m_q.size() < DEPTH || pop) push = 1;
                    else m_ovf = 1;
                end
                if (raster_done) m_state = 2;
            end
            default: if (m_q.size() == 0) begin m_state = 0; nd = 1; end
        endcase
        if (pop) void'(m_q.pop_front());
        if (push) begin
            e.addr = AW'(ys * FBW + xs);
            e.data = m_color;
            m_q.push_back(e);
            if (m_frag < 65535) m_frag++;
        end
        m_done = nd;
        @(posedge clk);
        #1;
        chk("mem_valid", 32'(mem_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("mem_addr", 32'(mem_addr), 32'(m_q[0].addr));
            chk("mem_data", 32'(mem_data), 32'(m_q[0].data));
        end
        chk("busy", 32'(busy), 32'(m_state != 0));
        chk("done", 32'(done), 32'(m_done));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("frag_count", 32'(frag_count), 32'(m_frag));
        chk("clip_count", 32'(clip_count), 32'(m_clip));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", 32'(mem_valid), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_data", 32'(mem_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_counts", {frag_count, clip_count}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic begin_tri(input logic [COLW-1:0] c);
        start = 1; color = c; step(); start = 0;
    endtask

    task automatic frag(input int x, input int y);
        frag_valid = 1; frag_x = CW'(x); frag_y = CW'(y); step(); frag_valid = 0;
    endtask

    task automatic end_tri();
        raster_done = 1; step(); raster_done = 0;
    endtask

    task automatic wait_done(input bit rnd_ready);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            mem_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            if (done) seen = 1;
        end
        chk("done_seen", 32'(seen), 1);
    endtask

    typedef struct { int x; int y; bit v; int addr; } vec_t;
    vec_t tbl[12];

    initial begin
        int n_in, n_clip;
        tbl[0]  = '{0, 0, 1, 0};
        tbl[1]  = '{5, 2, 1, 1285};
        tbl[2]  = '{639, 479, 1, 307199};
        tbl[3]  = '{-1, 0, 0, 0};
        tbl[4]  = '{640, 3, 0, 0};
        tbl[5]  = '{2, 480, 0, 0};
        tbl[6]  = '{3, -5, 0, 0};
        tbl[7]  = '{-1024, 0, 0, 0};
        tbl[8]  = '{1023, 1023, 0, 0};
        tbl[9]  = '{0, 479, 1, 306560};
        tbl[10] = '{639, 0, 1, 639};
        tbl[11] = '{1, 1, 1, 641};

        do_reset();
        step();

        // Table: one triangle, one fragment per cycle, memory always ready.
        mem_ready = 1;
        begin_tri(16'hF800);
        n_in = 0; n_clip = 0;
        foreach (tbl[i]) begin
            frag(tbl[i].x, tbl[i].y);
            chk("tbl_valid", 32'(mem_valid), 32'(tbl[i].v));
            if (tbl[i].v) begin
                chk("tbl_addr", 32'(mem_addr), 32'(tbl[i].addr));
                chk("tbl_data", 32'(mem_data), 32'h0000F800);
                n_in++;
            end else n_clip++;
        end
        end_tri();
        wait_done(0);
        chk("tbl_frags", 32'(frag_count), 32'(n_in));
        chk("tbl_clips", 32'(clip_count), 32'(n_clip));
        step();
        chk("tbl_idle", 32'(busy), 0);

        // Overflow: memory stalled, 10 fragments into 8 entries.
        begin_tri(16'h1234);
        mem_ready = 0;
        for (int k = 0; k < 10; k++) frag(k, 1);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_frags", 32'(frag_count), 8);
        end_tri();
        mem_ready = 1;
        for (int k = 0; k < 8; k++) begin
            chk("ovf_order_valid", 32'(mem_valid), 1);
            chk("ovf_order_addr", 32'(mem_addr), 32'(640 + k));
            step();
        end
        chk("ovf_empty", 32'(mem_valid), 0);
        wait_done(0);

        // Full FIFO with a pop and a push in the same cycle.
        begin_tri(16'h0F0F);
        mem_ready = 0;
        for (int k = 0; k < 8; k++) frag(k, 2);
        mem_ready = 1;
        frag(100, 100);
        chk("full_no_ovf", 32'(overflow), 0);
        chk("full_frags", 32'(frag_count), 9);
        mem_ready = 0;
        frag(101, 100);
        chk("full_still8", 32'(overflow), 1);
        end_tri();
        wait_done(0);

        // Start pulsed during drain is ignored; the next real start takes effect.
        begin_tri(16'hAAAA);
        mem_ready = 0;
        for (int k = 0; k < 3; k++) frag(10 + k, 7);
        end_tri();
        start = 1; color = 16'h001F; step(); start = 0;
        chk("drain_busy", 32'(busy), 1);
        chk("drain_color", 32'(mem_data), 32'h0000AAAA);
        wait_done(0);
        begin_tri(16'h001F);
        chk("restart_frags", 32'(frag_count), 0);
        chk("restart_clips", 32'(clip_count), 0);
        chk("restart_ovf", 32'(overflow), 0);
        mem_ready = 1;
        frag(4, 4);
        chk("restart_color", 32'(mem_data), 32'h0000001F);
        end_tri();
        wait_done(0);

        // Reset with 3 writes queued: flushed, nothing issued afterwards.
        begin_tri(16'h5555);
        mem_ready = 0;
        for (int k = 0; k < 3; k++) frag(k, 9);
        do_reset();
        mem_ready = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("post_rst_quiet", 32'(mem_valid), 0);
        end

        // Randomized triangles with random backpressure.
        for (int t = 0; t < 6; t++) begin
            begin_tri(16'($urandom));
            for (int c = 0; c < 80; c++) begin
                mem_ready  = 1'($urandom_range(0, 1));
                frag_valid = ($urandom_range(0, 9) < 7);
                frag_x     = CW'($urandom_range(0, 760) - 60);
                frag_y     = CW'($urandom_range(0, 600) - 60);
                start      = ($urandom_range(0, 19) == 0);
                color      = 16'($urandom);
                step();
            end
            frag_valid = 0; start = 0;
            end_tri();
            wait_done(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
